// File: rtl/key_cond_pkg.sv
// Shared definitions for the push-button conditioner: per-key FSM state
// encoding and default 50 MHz timing constants.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES      = 500000;
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = 5000000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// One key channel: 2-FF synchroniser, debounce FSM, debounce and repeat
// counters, registered level and pulse outputs.
module key_debounce_fsm
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN            = 1,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                         REPEAT_PERIOD_CYCLES);
  localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] REP_FIRST = CW'(REPEAT_DELAY_CYCLES - 1);
  // After a repeat pulse the counter restarts PERIOD cycles short of the
  // first-repeat threshold, so one comparator serves both intervals
  // (requires PERIOD <= DELAY).
  localparam logic [CW-1:0] REP_RELOAD = CW'((REPEAT_PERIOD_CYCLES > REPEAT_DELAY_CYCLES) ?
                                             0 : REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES);

  logic [1:0]    sync_q;
  key_state_e    state_q, state_d;
  logic [CW-1:0] db_q, db_d;
  logic [CW-1:0] rep_q, rep_d;
  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          key_dn;

  assign key_dn = ~sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '1;
      state_q   <= IDLE;
      db_q      <= '0;
      rep_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      state_q   <= state_d;
      db_q      <= db_d;
      rep_q     <= rep_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    rep_d     = rep_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_dn) begin
          state_d = PRESS_WAIT;
          db_d    = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_dn) begin
          state_d = IDLE;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d   = HELD;
          db_d      = '0;
          rep_d     = '0;
          pressed_d = 1'b1;
          press_d   = 1'b1;
        end else begin
          db_d = (db_q == '1) ? db_q : db_q + 1'b1;
        end
      end
      HELD: begin
        if (!key_dn) begin
          state_d = RELEASE_WAIT;
          db_d    = '0;
        end else if ((REPEAT_EN != 0) && (rep_q == REP_FIRST)) begin
          press_d = 1'b1;
          rep_d   = REP_RELOAD;
        end else begin
          rep_d = (rep_q == '1) ? rep_q : rep_q + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (key_dn) begin
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          state_d   = IDLE;
          db_d      = '0;
          pressed_d = 1'b0;
          release_d = 1'b1;
        end else begin
          db_d = (db_q == '1) ? db_q : db_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pressed_o = pressed_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Board push-button conditioner: one independent debounce channel per key,
// producing pressed levels and press/repeat/release pulses.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned NUM_KEYS             = 3,
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN            = 1,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_KEYS-1:0] key_i,
  output logic [NUM_KEYS-1:0] pressed_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
      .REPEAT_EN            (REPEAT_EN),
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .key_i     (key_i[g]),
      .pressed_o (pressed_o[g]),
      .press_o   (press_o[g]),
      .release_o (release_o[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: streak-based reference model,
// per-cycle compare, directed latency/repeat/reset scenarios, random keys.
module tb_key_conditioner;
  localparam int NK = 3;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key = '1;
  logic [NK-1:0] pr1, ps1, rl1, pr0, ps0, rl0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
                    .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP)) dut_rep (
    .clk_i(clk), .rst_i(rst), .key_i(key),
    .pressed_o(pr1), .press_o(ps1), .release_o(rl1));

  key_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0),
                    .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP)) dut_norep (
    .clk_i(clk), .rst_i(rst), .key_i(key),
    .pressed_o(pr0), .press_o(ps0), .release_o(rl0));

  task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a level change is accepted after D+1 consecutive
  // synchronised samples disagreeing with the accepted level; repeats fire
  // at held-count RD, RD+RP, RD+2RP ... counting only settled held cycles.
  logic [1:0]    hist [NK];
  int            streak [NK];
  int            hcnt [NK];
  logic [NK-1:0] lvl, m_pr, m_ps1, m_ps0, m_rl;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NK; k++) begin
        hist[k] = 2'b11; streak[k] = 0; hcnt[k] = 0;
      end
      lvl = '0; m_pr = '0; m_ps1 = '0; m_ps0 = '0; m_rl = '0;
    end else begin
      m_ps1 = '0; m_ps0 = '0; m_rl = '0;
      for (int k = 0; k < NK; k++) begin
        logic seen;
        seen = ~hist[k][1];
        if (seen != lvl[k]) begin
          streak[k]++;
          if (streak[k] == D + 1) begin
            lvl[k] = seen;
            streak[k] = 0;
            if (seen) begin
              m_ps1[k] = 1'b1; m_ps0[k] = 1'b1; hcnt[k] = 0;
            end else begin
              m_rl[k] = 1'b1;
            end
          end
        end else begin
          if (lvl[k] && streak[k] == 0) begin
            hcnt[k]++;
            if (hcnt[k] == RD || (hcnt[k] > RD && (hcnt[k] - RD) % RP == 0))
              m_ps1[k] = 1'b1;
          end
          streak[k] = 0;
        end
        hist[k] = {hist[k][0], key[k]};
      end
      m_pr = lvl;
    end
  end

  always @(negedge clk) begin
    chk("cmp_pressed_rep", pr1, m_pr);
    chk("cmp_press_rep", ps1, m_ps1);
    chk("cmp_release_rep", rl1, m_rl);
    chk("cmp_pressed_norep", pr0, m_pr);
    chk("cmp_press_norep", ps0, m_ps0);
    chk("cmp_release_norep", rl0, m_rl);
  end

  int cnt, cnt0;
  int pos[$];
  int run[NK];

  initial begin
    tick(3);
    chk("reset_pressed", pr1, '0);
    chk("reset_press", ps1, '0);
    chk("reset_release", rl1, '0);
    rst = 1'b0;
    tick(3);

    // Clean press and release on key 0
    key = 3'b110;
    tick(6);
    chk("press0_before", ps1, 3'b000);
    chk("pressed0_before", pr1, 3'b000);
    tick(1);
    chk("press0_edge7", ps1, 3'b001);
    chk("pressed0_edge7", pr1, 3'b001);
    tick(1);
    chk("press0_single", ps1, 3'b000);
    key = 3'b111;
    tick(6);
    chk("release0_before", rl1, 3'b000);
    tick(1);
    chk("release0_edge7", rl1, 3'b001);
    chk("pressed0_cleared", pr1, 3'b000);
    tick(3);

    // Bouncy press on key 1
    cnt = 0;
    for (int b = 0; b < 2; b++) begin
      key[1] = 1'b0;
      for (int t = 0; t < 3; t++) begin tick(1); cnt += int'(ps1[1]); end
      key[1] = 1'b1;
      for (int t = 0; t < 3; t++) begin tick(1); cnt += int'(ps1[1]); end
    end
    key[1] = 1'b0;
    for (int t = 0; t < 6; t++) begin tick(1); cnt += int'(ps1[1]); end
    chki("bounce_no_press", cnt, 0);
    tick(1);
    chk("bounce_press_edge7", ps1 & 3'b010, 3'b010);

    // Hold with repeat on key 2
    key[2] = 1'b0;
    cnt0 = 0;
    for (int t = 1; t <= 45; t++) begin
      tick(1);
      if (ps1[2]) pos.push_back(t);
      cnt0 += int'(ps0[2]);
    end
    chki("repeat_count", pos.size(), 4);
    if (pos.size() == 4) begin
      chki("repeat_accept", pos[0], 7);
      chki("repeat_first", pos[1], 27);
      chki("repeat_second", pos[2], 35);
      chki("repeat_third", pos[3], 43);
    end
    chki("norepeat_count", cnt0, 1);
    tick(15);

    // Release bounce then clean release on key 2
    key[2] = 1'b1;
    tick(2);
    key[2] = 1'b0;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin tick(1); cnt += int'(rl1[2]); end
    chki("bounce_no_release", cnt, 0);
    chki("bounce_still_pressed", int'(pr1[2]), 1);
    key[2] = 1'b1;
    tick(6);
    chki("release2_before", int'(rl1[2]), 0);
    tick(1);
    chki("release2_edge7", int'(rl1[2]), 1);
    chki("pressed2_cleared", int'(pr1[2]), 0);

    // Async reset while key 0 (and key 1) held
    key[0] = 1'b0;
    tick(10);
    chki("held0_before_reset", int'(pr1[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_pressed", pr1, '0);
    chk("rst_async_press", ps1, '0);
    chk("rst_async_release", rl1, '0);
    chk("rst_async_pressed_norep", pr0, '0);
    tick(2);
    chk("rst_no_release", rl1, '0);
    rst = 1'b0;
    tick(6);
    chk("repress_before", ps1, 3'b000);
    tick(1);
    chk("repress_edge7", ps1, 3'b011);

    // All three keys pressed together
    key = '1;
    tick(20);
    key = '0;
    tick(6);
    chk("all_before", ps1, 3'b000);
    tick(1);
    chk("all_edge7", ps1, 3'b111);
    tick(1);
    chk("all_single", ps1, 3'b000);
    key = '1;
    tick(20);

    // Random run-length stimulus with occasional asynchronous resets
    for (int k = 0; k < NK; k++) run[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        if (run[k] == 0) begin
          key[k] = ~key[k];
          run[k] = ($urandom_range(1) == 0) ? int'($urandom_range(8, 1))
                                             : int'($urandom_range(60, 1));
        end
        run[k]--;
      end
      if ($urandom_range(399) == 0) begin
        #3 rst = 1'b1;
        #1 chk("rand_rst_outputs", pr1 | ps1 | rl1, '0);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
